// File: rtl/hpdmc_rdctl.sv
// Purpose: read-capture sequencer. It tracks each accepted SDRAM read through its CAS latency,
//          gates the IDDR2 capture bank and registers the captured pairs into a wide read word.
// Latency: CE is asserted at T+L and T+L+1, and data is valid at T+L+1 and T+L+2 (L = clamped tim_cas).
// Backpressure: none. A read that would collide is dropped and flagged in the sticky overlap_err.
module hpdmc_rdctl #(
    parameter int DQ_WIDTH = 32,
    parameter int CL_MAX   = 7,
    parameter int CLW      = 3
) (
    input  logic                  sys_clk,
    input  logic                  sdram_rst,
    input  logic                  read,
    input  logic [CLW-1:0]        tim_cas,
    output logic                  iddr_ce,
    input  logic [DQ_WIDTH-1:0]   iddr_q0,
    input  logic [DQ_WIDTH-1:0]   iddr_q1,
    output logic [2*DQ_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  read_busy,
    output logic                  overlap_err,
    input  logic                  err_clr
);

    // Bit k of the CE line means "CE is high k cycles from now"; bit 0 drives iddr_ce directly.
    // The top bit is only ever observed by the collision check for L = CL_MAX.
    localparam int DL = CL_MAX + 2;

    logic [DL-1:0]           ce_line_q, ce_line_d;
    logic [DL-1:0]           first_q, first_d;      // marks the first CE of each burst
    logic                    acc_q, acc_d;          // a read was accepted last cycle
    logic [2*DQ_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [CLW-1:0]          lat;
    logic                    slot_busy;
    logic                    accept;
    logic                    reject;

    // Clamp the latency, check collisions, and compute the next state of the delay line and output stage.
    always_comb begin
        lat = tim_cas;
        if (tim_cas == '0) begin
            lat = CLW'(1);
        end else if (tim_cas > CLW'(CL_MAX)) begin
            lat = CLW'(CL_MAX);
        end

        // The new burst would own CE slots now+L and now+L+1; either one being taken is a collision.
        slot_busy = 1'b0;
        for (int k = 0; k < DL; k++) begin
            if ((k == int'(lat)) || (k == int'(lat) + 1)) begin
                slot_busy = slot_busy | ce_line_q[k];
            end
        end

        accept = read && !acc_q && !slot_busy;
        reject = read && !accept;
        acc_d  = accept;

        // After the shift, slot offsets L and L+1 land at new positions L-1 and L.
        for (int k = 0; k < DL - 1; k++) begin
            ce_line_d[k] = ce_line_q[k+1] |
                           (accept && ((k == int'(lat) - 1) || (k == int'(lat))));
            first_d[k]   = first_q[k+1] | (accept && (k == int'(lat) - 1));
        end
        ce_line_d[DL-1] = 1'b0;
        first_d[DL-1]   = 1'b0;

        rd_valid_d = ce_line_q[0];
        rd_last_d  = ce_line_q[0] & ~first_q[0];
        rd_data_d  = ce_line_q[0] ? {iddr_q0, iddr_q1} : rd_data_q;
        busy_d     = (|ce_line_d) | rd_valid_d;

        // When a rejection and a clear happen in the same cycle, the set wins.
        err_d = err_q;
        if (reject) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // State registers. A reset discards every in-flight token.
    always_ff @(posedge sys_clk) begin
        if (sdram_rst) begin
            ce_line_q  <= '0;
            first_q    <= '0;
            acc_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ce_line_q  <= ce_line_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign iddr_ce     = ce_line_q[0];
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign read_busy   = busy_q;
    assign overlap_err = err_q;

endmodule

// File: tb/tb_hpdmc_rdctl.sv
// Bench for hpdmc_rdctl: a directed vector table followed by randomized traffic.
// Expected per-cycle waveforms are built up front from burst-placement rules, then compared each cycle.
// Outputs are sampled on the falling edge, and inputs are driven just after the rising edge.
module tb_hpdmc_rdctl;

    localparam int DQ_WIDTH = 32;
    localparam int CL_MAX   = 7;
    localparam int CLW      = 3;
    localparam int N        = 1500;
    localparam int RND_LO   = 200;
    localparam int RND_HI   = N - 25;

    logic                  sys_clk = 1'b0;
    logic                  sdram_rst;
    logic                  read;
    logic [CLW-1:0]        tim_cas;
    logic                  iddr_ce;
    logic [DQ_WIDTH-1:0]   iddr_q0;
    logic [DQ_WIDTH-1:0]   iddr_q1;
    logic [2*DQ_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  read_busy;
    logic                  overlap_err;
    logic                  err_clr;

    hpdmc_rdctl #(.DQ_WIDTH(DQ_WIDTH), .CL_MAX(CL_MAX), .CLW(CLW)) dut (
        .sys_clk    (sys_clk),
        .sdram_rst  (sdram_rst),
        .read       (read),
        .tim_cas    (tim_cas),
        .iddr_ce    (iddr_ce),
        .iddr_q0    (iddr_q0),
        .iddr_q1    (iddr_q1),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .read_busy  (read_busy),
        .overlap_err(overlap_err),
        .err_clr    (err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int       cyc;
        bit       rd;
        bit       clr;
        bit       rst;
        bit [2:0] cas;
        bit       exp_acc;
        int       exp_lat;
        bit       exp_err_next;
    } vec_t;

    vec_t tbl [20];

    // Per-cycle stimulus
    bit        rd_a  [N];
    bit        clr_a [N];
    bit        rst_a [N];
    bit [2:0]  cas_a [N];
    bit [63:0] qv    [N];
    int        didx  [N];

    // Per-cycle expectations
    bit        e_ce   [N];
    bit        e_v    [N];
    bit        e_last [N];
    bit        e_busy [N];
    bit        e_err  [N];
    bit        e_acc  [N];
    bit [63:0] e_dat  [N];

    int checks = 0;
    int errors = 0;

    function automatic void place(int t, int l);
        e_ce[t+l]     = 1'b1;
        e_ce[t+l+1]   = 1'b1;
        e_v[t+l+1]    = 1'b1;
        e_v[t+l+2]    = 1'b1;
        e_last[t+l+2] = 1'b1;
        for (int k = t + 1; k <= t + l + 2; k++) e_busy[k] = 1'b1;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input int n);
        sdram_rst = rst_a[n];
        read      = rd_a[n];
        err_clr   = clr_a[n];
        tim_cas   = cas_a[n];
        iddr_q0   = qv[n][63:32];
        iddr_q1   = qv[n][31:0];
    endtask

    initial begin
        //         cyc  rd clr rst cas acc lat err_next
        tbl[0]  = '{10,  1, 0, 0, 3'd2, 1, 2, 0};  // single read, L=2
        tbl[1]  = '{30,  1, 0, 0, 3'd3, 1, 3, 0};  // back-to-back at spacing 2
        tbl[2]  = '{32,  1, 0, 0, 3'd3, 1, 3, 0};
        tbl[3]  = '{34,  1, 0, 0, 3'd3, 1, 3, 0};
        tbl[4]  = '{50,  1, 0, 0, 3'd2, 1, 2, 0};
        tbl[5]  = '{51,  1, 0, 0, 3'd2, 0, 0, 1};  // adjacent read rejected
        tbl[6]  = '{60,  0, 1, 0, 3'd0, 0, 0, 0};  // clear
        tbl[7]  = '{70,  1, 0, 0, 3'd5, 1, 5, 0};
        tbl[8]  = '{72,  0, 1, 0, 3'd0, 0, 0, 0};
        tbl[9]  = '{74,  1, 0, 0, 3'd1, 0, 0, 1};  // CE slot collision
        tbl[10] = '{80,  0, 1, 0, 3'd0, 0, 0, 0};
        tbl[11] = '{90,  1, 0, 0, 3'd5, 1, 5, 0};
        tbl[12] = '{94,  1, 0, 0, 3'd3, 1, 3, 0};  // fits right behind: CE 95..98
        tbl[13] = '{110, 1, 0, 0, 3'd0, 1, 1, 0};  // 0 acts as 1
        tbl[14] = '{120, 1, 0, 0, 3'd7, 1, 7, 0};  // maximum latency
        tbl[15] = '{140, 1, 0, 0, 3'd4, 1, 4, 0};
        tbl[16] = '{144, 0, 0, 1, 3'd0, 0, 0, 0};  // reset at first CE
        tbl[17] = '{160, 1, 0, 0, 3'd2, 1, 2, 0};
        tbl[18] = '{161, 1, 1, 0, 3'd2, 0, 0, 1};  // reject and clear together: set wins
        tbl[19] = '{170, 0, 1, 0, 3'd0, 0, 0, 0};

        for (int n = 0; n < N; n++) begin
            rd_a[n] = 0; clr_a[n] = 0; rst_a[n] = 0; didx[n] = -1;
            cas_a[n] = 3'($urandom_range(0, 7));
            e_ce[n] = 0; e_v[n] = 0; e_last[n] = 0; e_busy[n] = 0;
            e_err[n] = 0; e_acc[n] = 0; e_dat[n] = '0;
            if (n < RND_LO) qv[n] = {32'(n), 32'(n) ^ 32'hA5A5_0000};
            else            qv[n] = {$urandom, $urandom};
        end
        rst_a[0] = 1; rst_a[1] = 1;
        for (int i = 0; i < 20; i++) begin
            didx[tbl[i].cyc]  = i;
            rd_a[tbl[i].cyc]  = tbl[i].rd;
            clr_a[tbl[i].cyc] = tbl[i].clr;
            rst_a[tbl[i].cyc] = tbl[i].rst;
            cas_a[tbl[i].cyc] = tbl[i].cas;
        end
        for (int n = RND_LO; n < RND_HI; n++) begin
            rd_a[n]  = ($urandom_range(0, 99) < 45);
            clr_a[n] = ($urandom_range(0, 99) < 6);
            rst_a[n] = ($urandom_range(0, 99) < 2);
        end

        // Build the expected waveforms cycle by cycle
        for (int n = 0; n < N - 1; n++) begin
            int L;
            bit acc;
            bit rej;
            acc = 0; rej = 0; L = 0;
            if (rst_a[n]) begin
                for (int k = n + 1; k < N; k++) begin
                    e_ce[k] = 0; e_v[k] = 0; e_last[k] = 0; e_busy[k] = 0;
                end
                e_err[n+1] = 0;
                e_dat[n+1] = '0;
            end else begin
                e_dat[n+1] = e_ce[n] ? qv[n] : e_dat[n];
                if (didx[n] >= 0) begin
                    acc        = tbl[didx[n]].exp_acc;
                    L          = tbl[didx[n]].exp_lat;
                    e_err[n+1] = tbl[didx[n]].exp_err_next;
                end else begin
                    L = (cas_a[n] == 0) ? 1 : ((int'(cas_a[n]) > CL_MAX) ? CL_MAX : int'(cas_a[n]));
                    if (rd_a[n]) begin
                        acc = !(n > 0 && e_acc[n-1]) && !e_ce[n+L] && !e_ce[n+L+1];
                        rej = !acc;
                    end
                    e_err[n+1] = rej ? 1'b1 : (clr_a[n] ? 1'b0 : e_err[n]);
                end
                e_acc[n] = acc;
                if (acc) place(n, L);
            end
        end

        drive(0);
        for (int n = 1; n < N; n++) begin
            @(posedge sys_clk);
            #1;
            drive(n);
            @(negedge sys_clk);
            chk("iddr_ce",     n, 64'(iddr_ce),     64'(e_ce[n]));
            chk("rd_valid",    n, 64'(rd_valid),    64'(e_v[n]));
            chk("rd_last",     n, 64'(rd_last),     64'(e_last[n]));
            chk("read_busy",   n, 64'(read_busy),   64'(e_busy[n]));
            chk("overlap_err", n, 64'(overlap_err), 64'(e_err[n]));
            chk("rd_data",     n, rd_data,          e_dat[n]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
